// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline:
// ALU opcode encodings, the zero-register index and the packed decode control bundle.
package mips_pipe_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned REG_ZERO = 0;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'h8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'h9;
    localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'hA;

    // Decoded control carried from ID into EX as a single registered field
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                alu_src;
        logic                reg_dst;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding mux for one EX source operand.
// EX/MEM result beats MEM/WB data, which beats the registered read data;
// register 0 is hard-wired to zero and therefore never forwarded.
module fwd_unit
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_idx,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] fwd_val
);

    // Priority select of the newest in-flight value for src_idx
    always_comb begin
        fwd_val = reg_val;
        if (exm_reg_write && (exm_rd != REG_AW'(REG_ZERO)) && (exm_rd == src_idx)) begin
            fwd_val = exm_result;
        end else if (mwb_reg_write && (mwb_rd != REG_AW'(REG_ZERO)) && (mwb_rd == src_idx)) begin
            fwd_val = mwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// A load in EX whose destination is read by the instruction in ID costs one
// bubble; the load value then reaches the consumer through MEM/WB forwarding.
// A taken branch (flush) squashes the decode slot and overrides any stall.
// Optional build macro IDEX_PERF_CNT_EN adds stall/flush cycle counters.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_rs_used,
    input  logic               id_rt_used,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               flush,
    input  logic               exm_reg_write,
    input  logic [REG_AW-1:0]  exm_rd,
    input  logic [DATA_W-1:0]  exm_result,
    input  logic               mwb_reg_write,
    input  logic [REG_AW-1:0]  mwb_rd,
    input  logic [DATA_W-1:0]  mwb_data,
    output logic               stall,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_rs_val,
    output logic [DATA_W-1:0]  ex_rt_val,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_dst,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stalls,
    output logic [31:0]        perf_flushes
`endif
);

    logic              valid_q,   valid_d;
    ctrl_t             ctrl_q,    ctrl_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] dst_q,     dst_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic              load_use;
    logic              unused_reg_dst;

    // Load in EX feeding a source the ID instruction actually reads
    always_comb begin
        load_use = valid_q && ctrl_q.mem_read && (dst_q != REG_AW'(REG_ZERO)) && id_valid &&
                   ((id_rs_used && (id_rs == dst_q)) || (id_rt_used && (id_rt == dst_q)));
        stall    = load_use && !flush;
    end

    // Next EX slot: capture decode, or a bubble on flush / load-use
    always_comb begin
        valid_d          = id_valid;
        ctrl_d.reg_write = id_reg_write & id_valid;
        ctrl_d.mem_read  = id_mem_read  & id_valid;
        ctrl_d.mem_write = id_mem_write & id_valid;
        ctrl_d.alu_src   = id_alu_src;
        ctrl_d.reg_dst   = id_reg_dst;
        ctrl_d.alu_op    = ALU_OP_W'(id_alu_op);
        rs_d             = id_rs;
        rt_d             = id_rt;
        dst_d            = id_reg_dst ? id_rd : id_rt;
        rs_data_d        = id_rs_data;
        rt_data_d        = id_rt_data;
        imm_d            = id_imm;
        if (flush || load_use) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    // ID/EX register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_idx       (rs_q),
        .reg_val       (rs_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_data      (mwb_data),
        .fwd_val       (ex_rs_val)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_idx       (rt_q),
        .reg_val       (rt_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_data      (mwb_data),
        .fwd_val       (ex_rt_val)
    );

    assign ex_valid       = valid_q;
    assign ex_rt          = rt_q;
    assign ex_dst         = dst_q;
    assign ex_imm         = imm_q;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;
    assign ex_alu_src     = ctrl_q.alu_src;
    assign ex_alu_op      = ALUOP_W'(ctrl_q.alu_op);
    // Destination is already resolved at capture, so reg_dst is not consumed in EX
    assign unused_reg_dst = ctrl_q.reg_dst;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_stalls_q,  perf_stalls_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    // Free-running wrap-around event counters
    always_comb begin
        perf_stalls_d  = perf_stalls_q  + {31'd0, stall};
        perf_flushes_d = perf_flushes_q + {31'd0, flush};
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_stalls  = perf_stalls_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: forwarding vector table, hand-written hazard,
// flush and reset sequences, and a randomized run against a behavioural model.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    logic        clk, rst_n, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_rs_used, id_rt_used;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst;
    logic [3:0]  id_alu_op;
    logic        flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_data;
    logic        stall, ex_valid;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_rt, ex_dst;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [3:0]  ex_alu_op;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_stalls, perf_flushes;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the instruction sitting in EX
    logic        m_valid, m_rw, m_mr, m_mw, m_as;
    logic [3:0]  m_op;
    logic [4:0]  m_rs, m_rt, m_dst;
    logic [31:0] m_rsd, m_rtd, m_imm;
    int unsigned m_nstall, m_nflush;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .stall(stall), .ex_valid(ex_valid),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op)
`ifdef IDEX_PERF_CNT_EN
        , .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Newest producer of register s among the in-flight buses, else the read data
    function automatic logic [31:0] m_fwd(input logic [4:0] s, input logic [31:0] regv);
        if (s == 5'd0) return regv;
        if (exm_reg_write && exm_rd == s) return exm_result;
        if (mwb_reg_write && mwb_rd == s) return mwb_data;
        return regv;
    endfunction

    function automatic logic m_hazard();
        if (!(m_valid && m_mr && m_dst != 5'd0 && id_valid)) return 1'b0;
        return (id_rs_used && id_rs == m_dst) || (id_rt_used && id_rt == m_dst);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_as = 0; m_op = 0;
        m_rs = 0; m_rt = 0; m_dst = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
        m_nstall = 0; m_nflush = 0;
    endtask

    task automatic model_edge();
        if (m_hazard() && !flush) m_nstall++;
        if (flush) m_nflush++;
        if (flush || m_hazard()) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else begin
            m_valid = id_valid;
            m_rw  = id_valid && id_reg_write;
            m_mr  = id_valid && id_mem_read;
            m_mw  = id_valid && id_mem_write;
            m_as  = id_alu_src;
            m_op  = id_alu_op;
            m_rs  = id_rs;
            m_rt  = id_rt;
            m_dst = id_reg_dst ? id_rd : id_rt;
            m_rsd = id_rs_data;
            m_rtd = id_rt_data;
            m_imm = id_imm;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("stall", 32'(stall), 32'(m_hazard() && !flush));
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m_mw));
        if (m_valid) begin
            chk("ex_rs_val", ex_rs_val, m_fwd(m_rs, m_rsd));
            chk("ex_rt_val", ex_rt_val, m_fwd(m_rt, m_rtd));
            chk("ex_rt", 32'(ex_rt), 32'(m_rt));
            chk("ex_dst", 32'(ex_dst), 32'(m_dst));
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_alu_src", 32'(ex_alu_src), 32'(m_as));
            chk("ex_alu_op", 32'(ex_alu_op), 32'(m_op));
        end
    endtask

    task automatic idle_all();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_used = 0; id_rt_used = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_src = 0; id_reg_dst = 0;
        id_alu_op = 0; flush = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    // Present an instruction in decode (R-type if reg_dst, else I-type writing rt)
    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic rw, input logic mr, input logic rdst);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_used = 1; id_rt_used = 1; id_rs_data = rsd; id_rt_data = rtd;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 0; id_reg_dst = rdst;
        id_alu_src = mr; id_alu_op = ALU_ADD; id_imm = 32'h10;
    endtask

    typedef struct {
        logic [4:0]  rs;
        logic [31:0] rsd;
        logic        ew;
        logic [4:0]  erd;
        logic [31:0] eres;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic [31:0] exp;
    } fwd_vec_t;

    fwd_vec_t vecs[8];

    initial begin
        vecs[0] = '{5'd3,  32'h11,   1'b1, 5'd3,  32'h3,    1'b0, 5'd0,  32'h0,    32'h3};
        vecs[1] = '{5'd3,  32'h11,   1'b1, 5'd5,  32'h9,    1'b1, 5'd3,  32'h3,    32'h3};
        vecs[2] = '{5'd3,  32'h11,   1'b1, 5'd3,  32'h7,    1'b1, 5'd3,  32'h3,    32'h7};
        vecs[3] = '{5'd0,  32'h0,    1'b1, 5'd0,  32'hDEAD, 1'b0, 5'd0,  32'h0,    32'h0};
        vecs[4] = '{5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hBEEF, 32'h0};
        vecs[5] = '{5'd4,  32'h44,   1'b0, 5'd4,  32'h99,   1'b0, 5'd4,  32'h77,   32'h44};
        vecs[6] = '{5'd4,  32'h44,   1'b1, 5'd5,  32'h1,    1'b1, 5'd6,  32'h2,    32'h44};
        vecs[7] = '{5'd31, 32'hAAAA, 1'b0, 5'd0,  32'h0,    1'b1, 5'd31, 32'h5555, 32'h5555};

        idle_all();
        model_reset();
        rst_n = 0;
        #12;
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_ex_reg_write", 32'(ex_reg_write), 32'h0);
        chk("rst_ex_mem_read", 32'(ex_mem_read), 32'h0);
        chk("rst_ex_rs_val", ex_rs_val, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Forwarding table: load a reader of rs, then drive the forward buses
        for (int i = 0; i < 8; i++) begin
            idle_all();
            set_id(vecs[i].rs, 5'd1, 5'd2, vecs[i].rsd, 32'h0, 1'b1, 1'b0, 1'b1);
            tick();
            exm_reg_write = vecs[i].ew; exm_rd = vecs[i].erd; exm_result = vecs[i].eres;
            mwb_reg_write = vecs[i].mw; mwb_rd = vecs[i].mrd; mwb_data = vecs[i].mdat;
            #1;
            chk($sformatf("fwd_vec%0d", i), ex_rs_val, vecs[i].exp);
        end

        // Back-to-back ALU: add r3=r1+r2 ; sub r4=r3-r1
        idle_all();
        set_id(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd3, 5'd1, 5'd4, 32'd0, 32'd1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("b2b_stall0", 32'(stall), 32'h0);
        tick();
        exm_reg_write = 1; exm_rd = 5'd3; exm_result = 32'd3;
        #1;
        chk("b2b_rs_val", ex_rs_val, 32'd3);
        chk("b2b_rt_val", ex_rt_val, 32'd1);
        chk("b2b_dst", 32'(ex_dst), 32'd4);
        chk("b2b_stall1", 32'(stall), 32'h0);

        // Load-use: lw r8 ; add r9=r8+r1
        idle_all();
        set_id(5'd1, 5'd8, 5'd0, 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd8, 5'd1, 5'd9, 32'd0, 32'd1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lu_stall_first", 32'(stall), 32'h1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
        chk("lu_bubble_rw", 32'(ex_reg_write), 32'h0);
        chk("lu_stall_second", 32'(stall), 32'h0);
        tick();
        mwb_reg_write = 1; mwb_rd = 5'd8; mwb_data = 32'h1234;
        #1;
        chk("lu_add_valid", 32'(ex_valid), 32'h1);
        chk("lu_add_rs_val", ex_rs_val, 32'h1234);
        chk("lu_add_rt_val", ex_rt_val, 32'd1);

        // Load targeting r0 followed by a reader of r0: no stall
        idle_all();
        set_id(5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("r0_load_stall", 32'(stall), 32'h0);
        tick();

        // Flush together with a load-use hazard
        idle_all();
        set_id(5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd8, 5'd8, 5'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        flush = 1;
        #1;
        chk("flush_stall", 32'(stall), 32'h0);
        tick();
        flush = 0;
        #1;
        chk("flush_valid", 32'(ex_valid), 32'h0);
        chk("flush_rw", 32'(ex_reg_write), 32'h0);
        chk("flush_mr", 32'(ex_mem_read), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            id_valid     = 1'($urandom_range(0, 3) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_rd        = 5'($urandom_range(0, 3));
            id_rs_used   = 1'($urandom_range(0, 1));
            id_rt_used   = 1'($urandom_range(0, 1));
            id_rs_data   = $urandom;
            id_rt_data   = $urandom;
            id_imm       = $urandom;
            id_reg_write = 1'($urandom_range(0, 1));
            id_mem_read  = 1'($urandom_range(0, 1));
            id_mem_write = 1'($urandom_range(0, 1));
            id_alu_src   = 1'($urandom_range(0, 1));
            id_reg_dst   = 1'($urandom_range(0, 1));
            id_alu_op    = 4'($urandom_range(0, 15));
            flush        = 1'($urandom_range(0, 7) == 0);
            exm_reg_write = 1'($urandom_range(0, 1));
            exm_rd        = 5'($urandom_range(0, 3));
            exm_result    = $urandom;
            mwb_reg_write = 1'($urandom_range(0, 1));
            mwb_rd        = 5'($urandom_range(0, 3));
            mwb_data      = $urandom;
            #1;
            check_model();
            tick();
        end

`ifdef IDEX_PERF_CNT_EN
        idle_all();
        #1;
        chk("perf_stalls", perf_stalls, m_nstall);
        chk("perf_flushes", perf_flushes, m_nflush);
`endif

        // Asynchronous reset in the middle of a stall
        idle_all();
        set_id(5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd8, 5'd1, 5'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("mid_stall_before", 32'(stall), 32'h1);
        rst_n = 0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'h0);
        chk("arst_rw", 32'(ex_reg_write), 32'h0);
        chk("arst_mr", 32'(ex_mem_read), 32'h0);
        chk("arst_stall", 32'(stall), 32'h0);
`ifdef IDEX_PERF_CNT_EN
        chk("arst_perf_stalls", perf_stalls, 32'h0);
        chk("arst_perf_flushes", perf_flushes, 32'h0);
`endif
        model_reset();
        rst_n = 1;
        tick();
        #1;
        check_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipe. Captures the two register-file read operands, decoded control and immediate from decode, and presents them to execute.
- Contains the operand forwarding unit, muxing EX/MEM and MEM/WB results onto the outgoing operands.
- Contains load-use hazard detection: raises a one-cycle stall and inserts a bubble.
- Squashes on a branch flush.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register index width
- ALUOP_W, 4, ALU opcode width

Ports:
- clk  in  1  pipeline clock, rising edge (register file writes on negedge)
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW  source/dest indices from decode
- id_rs_used, id_rt_used  in  1  instruction actually reads rs/rt
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst  in  1  decoded control
- id_alu_op  in  ALUOP_W  ALU opcode
- flush  in  1  branch taken in EX: squash decode slot
- exm_reg_write  in  1  EX/MEM writes a register
- exm_rd  in  REG_AW  EX/MEM destination
- exm_result  in  DATA_W  EX/MEM ALU result
- mwb_reg_write  in  1  MEM/WB writes a register
- mwb_rd  in  REG_AW  MEM/WB destination
- mwb_data  in  DATA_W  MEM/WB write-back data
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX slot holds a real instruction
- ex_rs_val, ex_rt_val  out  DATA_W  forwarded operands (combinational from registers + forward buses)
- ex_rt, ex_dst  out  REG_AW  rt index; resolved destination (id_reg_dst ? id_rd : id_rt)
- ex_imm  out  DATA_W  registered immediate
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1  registered control
- ex_alu_op  out  ALUOP_W  registered ALU opcode

Behaviour:
- Reset (async, rst_n=0):
  - all registered outputs 0; ex_valid=0.
  - Forwarded operands then reduce to the mux of zeroed registers.
- Load-use hazard:
  - condition: ex_valid & ex_mem_read & ex_dst!=0 & id_valid & ((id_rs_used & id_rs==ex_dst) | (id_rt_used & id_rt==ex_dst)).
  - stall = hazard & ~flush.
- Rising edge, priority order:
  1. flush: load bubble (ex_valid=0; reg_write, mem_read, mem_write all 0).
  2. stall: load bubble; upstream holds the ID instruction, which is re-presented next cycle.
  3. otherwise: capture all id_* fields; ex_valid=id_valid. A captured invalid slot forces all write/mem control to 0.
- Stall lasts exactly one cycle per load-use pair. The next cycle the load sits in MEM, and its data arrives later via MEM/WB forwarding.
- Forwarding, per operand, using registered index s (rs or rt):
  - exm_reg_write & exm_rd!=0 & exm_rd==s -> exm_result;
  - else mwb_reg_write & mwb_rd!=0 & mwb_rd==s -> mwb_data;
  - else registered read data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Bubbles still drive forwarded values, but ex_valid=0 and write control is 0, so they have no architectural effect.
- Write-back to the same register in the decode cycle is resolved by the negedge register-file write. No ID-side bypass here.
- Flush with stall in the same cycle: flush wins, stall=0, bubble inserted.
- Reset mid-stall: stall drops immediately, because ex_valid=0.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined: adds outputs perf_stalls and perf_flushes (32-bit). They count cycles with stall=1 and flush=1, reset to 0, and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package mips_pipe_pkg holds:
  - the ALU opcode constants;
  - REG_ZERO=0;
  - the packed control struct (reg_write, mem_read, mem_write, alu_src, reg_dst, alu_op), registered as one field.
- Sub-module fwd_unit: purely combinational 3-way priority mux, instantiated once per operand.

Test Plan:
- Back-to-back ALU: add r3=r1+r2 then sub r4=r3-r1 (r1=1, r2=2) -> second instr's ex_rs_val=3 via exm_result; stall never asserted.
- Distance-2 dependency: r3 producer two instrs ahead, intervening instr writes r5 -> operand from mwb_data=3. Both buses match r3 with different values (exm=7, mwb=3) -> 7 chosen.
- Load-use: lw r8 then add r9=r8+r1 -> stall=1 for exactly one cycle, bubble with ex_valid=0, then add enters EX with r8 forwarded from mwb_data.
- Register 0: exm_rd=0, exm_result=0xDEAD, id_rs=0 -> ex_rs_val=0. lw targeting r0 followed by a user of r0 -> no stall.
- Flush with hazard: lw r8 in EX, dependent instr in ID, flush=1 -> stall=0, bubble loaded, ex_reg_write=0.
- Reset mid-operation: drop rst_n between edges -> ex_valid, control, stall go 0 asynchronously. With IDEX_PERF_CNT_EN, counters read 0.
